mem_stage: RTL

Memory-access stage of the 5-stage MIPS pipeline, placed directly downstream of the execute stage. Consumes the EX/MEM-latched ALU result, store data and control flags; performs byte/halfword/word loads and stores against an internal little-endian data memory. Resolves the branch decision for the fetch stage and registers everything write-back needs in an internal MEM/WB register. Also exposes a combinational debug read port for the debug unit.

---
 rtl/mem_stage.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// Memory-access stage: little-endian data memory with byte/halfword/word
// loads and stores, branch resolution, and the MEM/WB pipeline register.
module mem_stage #(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_PC   = 32,
  parameter int unsigned NB_REG  = 5,
  parameter int unsigned NB_ADDR = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_MEM_enable,
  input  logic               i_MEM_reg_write,
  input  logic               i_MEM_mem_to_reg,
  input  logic               i_MEM_r31_ctrl,
  input  logic               i_MEM_hlt,
  input  logic               i_MEM_mem_read,
  input  logic               i_MEM_mem_write,
  input  logic               i_MEM_signed,
  input  logic               i_MEM_byte_en,
  input  logic               i_MEM_halfword_en,
  input  logic               i_MEM_word_en,
  input  logic               i_MEM_branch,
  input  logic               i_MEM_zero,
  input  logic [NB_PC-1:0]   i_MEM_branch_addr,
  input  logic [NB_DATA-1:0] i_MEM_alu_result,
  input  logic [NB_DATA-1:0] i_MEM_data_b,
  input  logic [NB_REG-1:0]  i_MEM_selected_reg,
  input  logic [NB_PC-1:0]   i_MEM_pc,
  input  logic [NB_ADDR-1:0] i_MEM_du_addr,
  output logic [NB_DATA-1:0] o_MEM_du_data,
  output logic               o_MEM_pc_src,
  output logic [NB_PC-1:0]   o_MEM_branch_addr,
  output logic               o_WB_reg_write,
  output logic               o_WB_mem_to_reg,
  output logic               o_WB_r31_ctrl,
  output logic               o_WB_hlt,
  output logic               o_WB_misaligned,
  output logic [NB_DATA-1:0] o_WB_mem_data,
  output logic [NB_DATA-1:0] o_WB_alu_result,
  output logic [NB_REG-1:0]  o_WB_selected_reg,
  output logic [NB_PC-1:0]   o_WB_pc
);

  localparam int unsigned DEPTH = 1 << NB_ADDR;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  logic [NB_DATA-1:0] mem [DEPTH];

  logic [NB_ADDR-1:0] word_idx;
  logic [1:0]         lane;
  size_e              size;
  logic               misaligned;
  logic               halted;
  logic               commit;
  logic               mem_we;
  logic [NB_DATA-1:0] cur_word;
  logic [NB_DATA-1:0] load_data;
  logic [NB_DATA-1:0] wr_mask;
  logic [NB_DATA-1:0] wr_data;
  logic [7:0]         ld_byte;
  logic [15:0]        ld_half;

  // Address bits above the word index are deliberately ignored (wrap).
  logic unused_addr_bits;
  assign unused_addr_bits = ^i_MEM_alu_result[NB_DATA-1:NB_ADDR+2];

  assign word_idx = i_MEM_alu_result[NB_ADDR+1:2];
  assign lane     = i_MEM_alu_result[1:0];
  assign cur_word = mem[word_idx];

  assign o_MEM_du_data     = mem[i_MEM_du_addr];
  assign o_MEM_pc_src      = i_MEM_branch & i_MEM_zero;
  assign o_MEM_branch_addr = i_MEM_branch_addr;

  always_comb begin
    size = SZ_WORD;
    if (i_MEM_word_en)          size = SZ_WORD;
    else if (i_MEM_halfword_en) size = SZ_HALF;
    else if (i_MEM_byte_en)     size = SZ_BYTE;
  end

  // Only real memory accesses can be misaligned; plain ALU ops pass through.
  always_comb begin
    misaligned = 1'b0;
    if (i_MEM_mem_read || i_MEM_mem_write) begin
      case (size)
        SZ_HALF: misaligned = lane[0];
        SZ_WORD: misaligned = (lane != 2'b00);
        default: misaligned = 1'b0;
      endcase
    end
  end

  assign commit = i_MEM_enable & ~halted;
  assign mem_we = commit & i_MEM_mem_write & ~misaligned;

  always_comb begin
    ld_byte   = cur_word[{lane, 3'b000} +: 8];
    ld_half   = lane[1] ? cur_word[31:16] : cur_word[15:0];
    load_data = '0;
    if (i_MEM_mem_read && !misaligned) begin
      case (size)
        SZ_BYTE: load_data = {{(NB_DATA-8){i_MEM_signed & ld_byte[7]}}, ld_byte};
        SZ_HALF: load_data = {{(NB_DATA-16){i_MEM_signed & ld_half[15]}}, ld_half};
        default: load_data = cur_word;
      endcase
    end
  end

  always_comb begin
    wr_mask = '1;
    wr_data = i_MEM_data_b;
    case (size)
      SZ_BYTE: begin
        wr_mask = NB_DATA'(32'h0000_00FF) << {lane, 3'b000};
        wr_data = {4{i_MEM_data_b[7:0]}};
      end
      SZ_HALF: begin
        wr_mask = lane[1] ? NB_DATA'(32'hFFFF_0000) : NB_DATA'(32'h0000_FFFF);
        wr_data = {2{i_MEM_data_b[15:0]}};
      end
      default: begin
        wr_mask = '1;
        wr_data = i_MEM_data_b;
      end
    endcase
  end

  // Memory is never cleared; a store is dropped if reset is low at the edge.
  always_ff @(posedge i_clk) begin
    if (mem_we && i_reset) begin
      mem[word_idx] <= (cur_word & ~wr_mask) | (wr_data & wr_mask);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      halted            <= 1'b0;
      o_WB_reg_write    <= 1'b0;
      o_WB_mem_to_reg   <= 1'b0;
      o_WB_r31_ctrl     <= 1'b0;
      o_WB_hlt          <= 1'b0;
      o_WB_misaligned   <= 1'b0;
      o_WB_mem_data     <= '0;
      o_WB_alu_result   <= '0;
      o_WB_selected_reg <= '0;
      o_WB_pc           <= '0;
    end else if (commit) begin
      halted            <= i_MEM_hlt;
      o_WB_reg_write    <= i_MEM_reg_write & ~misaligned;
      o_WB_mem_to_reg   <= i_MEM_mem_to_reg;
      o_WB_r31_ctrl     <= i_MEM_r31_ctrl;
      o_WB_hlt          <= i_MEM_hlt;
      o_WB_misaligned   <= misaligned;
      o_WB_mem_data     <= load_data;
      o_WB_alu_result   <= i_MEM_alu_result;
      o_WB_selected_reg <= i_MEM_selected_reg;
      o_WB_pc           <= i_MEM_pc;
    end
  end

endmodule
